// File: rtl/pwm_axil_slave.sv
// AXI4-Lite register block (CTRL/PERIOD/DUTY/COUNT) driving a single PWM output.
// PERIOD/DUTY are copied into active registers only at period boundaries, or continuously while disabled.
`timescale 1ns/1ps
module pwm_axil_slave #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic                    pwm_out,
    output logic                    period_tick
);

    logic                   aw_full_q, aw_full_d;
    logic [1:0]             aw_addr_q, aw_addr_d;
    logic                   w_full_q, w_full_d;
    logic [31:0]            w_data_q, w_data_d;
    logic [3:0]             w_strb_q, w_strb_d;
    logic                   bvalid_q, bvalid_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic [C_CNT_WIDTH-1:0] period_q, period_d;
    logic [C_CNT_WIDTH-1:0] duty_q, duty_d;
    logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [C_CNT_WIDTH-1:0] act_period_q, act_period_d;
    logic [C_CNT_WIDTH-1:0] act_duty_q, act_duty_d;
    logic                   raw_q, raw_d;

    logic        aw_hs, w_hs, ar_hs, wrap;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0]  s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    // Readies are forced low while reset is held so nothing is accepted mid-reset.
    assign S_AXI_AWREADY = !ARESET && !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = !ARESET && !w_full_q && !bvalid_q;
    assign S_AXI_ARREADY = !ARESET && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign wr_addr = aw_full_q ? aw_addr_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;

    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_mux = {30'd0, ctrl_q};
            2'd1:    rd_mux = 32'(period_q);
            2'd2:    rd_mux = 32'(duty_q);
            default: rd_mux = 32'(cnt_q);
        endcase
    end

    assign wrap        = ctrl_q[0] && (cnt_q == act_period_q);
    assign period_tick = wrap;
    assign pwm_out     = raw_q ^ ctrl_q[1];

    always_comb begin
        aw_full_d    = aw_full_q;
        aw_addr_d    = aw_addr_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        ctrl_d       = ctrl_q;
        period_d     = period_q;
        duty_d       = duty_q;
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        raw_d        = raw_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (bvalid_q && S_AXI_BREADY)
            bvalid_d = 1'b0;
        // Commit on the edge where the second half arrives, so BVALID follows the last handshake by one cycle.
        if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            case (wr_addr)
                2'd0:    ctrl_d   = wr_strb[0] ? wr_data[1:0] : ctrl_q;
                2'd1:    period_d = C_CNT_WIDTH'(apply_strb(32'(period_q), wr_data, wr_strb));
                2'd2:    duty_d   = C_CNT_WIDTH'(apply_strb(32'(duty_q), wr_data, wr_strb));
                default: ;
            endcase
        end

        if (rvalid_q && S_AXI_RREADY)
            rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end

        if (!ctrl_q[0]) begin
            cnt_d        = '0;
            act_period_d = period_q;
            act_duty_d   = duty_q;
            raw_d        = 1'b0;
        end else begin
            raw_d = cnt_q < act_duty_q;
            if (wrap) begin
                cnt_d        = '0;
                act_period_d = period_q;
                act_duty_d   = duty_q;
            end else begin
                cnt_d = cnt_q + C_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            ctrl_q       <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            cnt_q        <= '0;
            act_period_q <= '0;
            act_duty_q   <= '0;
            raw_q        <= 1'b0;
        end else begin
            aw_full_q    <= aw_full_d;
            aw_addr_q    <= aw_addr_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            raw_q        <= raw_d;
        end
    end

endmodule

// File: tb/tb_pwm_axil_slave.sv
// Directed bench for pwm_axil_slave: AXI-Lite register access, write-channel ordering and PWM waveforms.
`timescale 1ns/1ps
module tb_pwm_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        pwm_out;
    logic        period_tick;

    int checks = 0;
    int errors = 0;

    logic [1:0]  bresp, rresp;
    logic [31:0] rd;
    logic [19:0] pw, tk, exp_pw, exp_tk;

    pwm_axil_slave #(.C_ADDR_WIDTH(4), .C_CNT_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        logic aw_ok, w_ok;
        n = 0; aw_ok = 0; w_ok = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        while (!(aw_ok && w_ok) && n < 50) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) w_ok = 1;
            @(negedge ACLK); n++;
            if (aw_ok) S_AXI_AWVALID = 0;
            if (w_ok) S_AXI_WVALID = 0;
        end
        while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
        r = S_AXI_BRESP;
        checks++;
        if (n >= 50) begin errors++; $display("FAIL write_timeout addr=%h got timeout exp bvalid", a); end
        @(negedge ACLK);
        S_AXI_BREADY = 0; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
        while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
        d = S_AXI_RDATA; r = S_AXI_RRESP;
        checks++;
        if (n >= 50) begin errors++; $display("FAIL read_timeout addr=%h got timeout exp rvalid", a); end
        @(negedge ACLK);
        S_AXI_RREADY = 0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge ACLK);
        while (!period_tick && n < 100) begin @(negedge ACLK); n++; end
        checks++;
        if (!period_tick) begin errors++; $display("FAIL tick_timeout got 0 exp 1"); end
    endtask

    // Index 0 is the first cycle after the sampled tick (counter == 0).
    task automatic collect(output logic [19:0] p, output logic [19:0] t);
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            p[i] = pwm_out; t[i] = period_tick;
        end
    endtask

    task automatic test_reset();
        ARESET = 1; S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs got %b exp 0000000",
                {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, pwm_out, period_tick});
        end
        checks++;
        if (S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", S_AXI_RDATA); end
        ARESET = 0;
        @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready got %b exp 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rresp);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, rd); end
        end
    endtask

    task automatic test_regmap();
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, bresp);
            checks++;
            if (bresp !== 2'b00) begin errors++; $display("FAIL regmap_bresp%0d got %b exp 00", i, bresp); end
        end
        axi_read(4'h0, rd, rresp);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL regmap_ctrl got %h exp 1", rd); end
        checks++;
        if (rresp !== 2'b00) begin errors++; $display("FAIL regmap_rresp got %b exp 00", rresp); end
        axi_read(4'h4, rd, rresp);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL regmap_period got %h exp 2", rd); end
        axi_read(4'h8, rd, rresp);
        checks++;
        if (rd !== 32'h3) begin errors++; $display("FAIL regmap_duty got %h exp 3", rd); end
        axi_read(4'hC, rd, rresp);
        checks++;
        if (rd > 32'h2) begin errors++; $display("FAIL regmap_count got %h exp <=2", rd); end
        axi_write(4'h0, 32'h0, 4'hF, bresp);
        axi_read(4'hC, rd, rresp);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL count_disabled got %h exp 0", rd); end
    endtask

    task automatic test_wstrb();
        axi_write(4'h4, 32'h11223344, 4'b0101, bresp);
        axi_read(4'h4, rd, rresp);
        checks++;
        if (rd !== 32'h00220044) begin errors++; $display("FAIL wstrb_period got %h exp 00220044", rd); end
        axi_write(4'h0, 32'hFFFFFFFF, 4'b1110, bresp);
        axi_read(4'h0, rd, rresp);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL wstrb_ctrl got %h exp 0", rd); end
        axi_write(4'hC, 32'h0000FFFF, 4'hF, bresp);
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL count_write_bresp got %b exp 00", bresp); end
        axi_read(4'hC, rd, rresp);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL count_write_ignored got %h exp 0", rd); end
    endtask

    task automatic test_w_before_aw();
        @(negedge ACLK);
        S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        checks++;
        if (S_AXI_WREADY !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b exp 1", S_AXI_WREADY); end
        @(negedge ACLK);
        S_AXI_WVALID = 0;
        checks++;
        if ({S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY} !== 3'b001) begin
            errors++; $display("FAIL wfirst_buffered got %b exp 001", {S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY});
        end
        repeat (2) @(negedge ACLK);
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0;
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL wfirst_bvalid_latency got %b exp 1", S_AXI_BVALID); end
        checks++;
        if (S_AXI_BRESP !== 2'b00) begin errors++; $display("FAIL wfirst_bresp got %b exp 00", S_AXI_BRESP); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
                errors++; $display("FAIL bhold%0d got %b exp 100", i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
            end
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
        checks++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
            errors++; $display("FAIL bdone got %b exp 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        end
        axi_read(4'h8, rd, rresp);
        checks++;
        if (rd !== 32'h5) begin errors++; $display("FAIL wfirst_duty got %h exp 5", rd); end
    endtask

    task automatic test_pwm_wave();
        axi_write(4'h4, 32'd9, 4'hF, bresp);
        axi_write(4'h8, 32'd3, 4'hF, bresp);
        axi_write(4'h0, 32'h1, 4'hF, bresp);
        wait_tick();
        collect(pw, tk);
        for (int i = 0; i < 20; i++) begin
            exp_pw[i] = ((i % 10) >= 1) && ((i % 10) <= 3);
            exp_tk[i] = (i % 10) == 9;
        end
        checks++;
        if (pw !== exp_pw) begin errors++; $display("FAIL pwm_d3 got %b exp %b", pw, exp_pw); end
        checks++;
        if (tk !== exp_tk) begin errors++; $display("FAIL tick_p9 got %b exp %b", tk, exp_tk); end
        axi_write(4'h0, 32'h3, 4'hF, bresp);
        wait_tick();
        collect(pw, tk);
        checks++;
        if (pw !== ~exp_pw) begin errors++; $display("FAIL pwm_pol got %b exp %b", pw, ~exp_pw); end
        checks++;
        if (tk !== exp_tk) begin errors++; $display("FAIL tick_pol got %b exp %b", tk, exp_tk); end
    endtask

    task automatic test_duty_update();
        axi_write(4'h0, 32'h1, 4'hF, bresp);
        wait_tick();
        fork
            axi_write(4'h8, 32'd7, 4'hF, bresp);
            collect(pw, tk);
        join
        for (int i = 0; i < 20; i++)
            exp_pw[i] = (i >= 1 && i <= 3) || (i >= 11 && i <= 17);
        checks++;
        if (pw !== exp_pw) begin errors++; $display("FAIL duty_update got %b exp %b", pw, exp_pw); end
    endtask

    task automatic test_boundaries();
        axi_write(4'h8, 32'd0, 4'hF, bresp);
        wait_tick(); wait_tick();
        collect(pw, tk);
        checks++;
        if (pw !== 20'h0) begin errors++; $display("FAIL duty0 got %b exp all 0", pw); end
        axi_write(4'h8, 32'd20, 4'hF, bresp);
        wait_tick(); wait_tick();
        collect(pw, tk);
        checks++;
        if (pw !== 20'hFFFFF) begin errors++; $display("FAIL duty_gt_period got %b exp all 1", pw); end
        axi_write(4'h4, 32'd0, 4'hF, bresp);
        wait_tick(); wait_tick();
        collect(pw, tk);
        checks++;
        if (tk !== 20'hFFFFF) begin errors++; $display("FAIL period0_tick got %b exp all 1", tk); end
        axi_read(4'hC, rd, rresp);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL period0_count got %h exp 0", rd); end
    endtask

    task automatic test_same_reg_rw();
        fork
            axi_write(4'h4, 32'd9, 4'hF, bresp);
            axi_read(4'h4, rd, rresp);
        join
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rw_collide got %h exp 0", rd); end
        axi_read(4'h4, rd, rresp);
        checks++;
        if (rd !== 32'd9) begin errors++; $display("FAIL rw_after got %h exp 9", rd); end
    endtask

    task automatic test_reset_mid();
        wait_tick(); wait_tick();
        checks++;
        if (pwm_out !== 1'b1) begin errors++; $display("FAIL premid_pwm got %b exp 1", pwm_out); end
        @(negedge ACLK);
        S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'd3; S_AXI_WSTRB = 4'hF;
        S_AXI_WVALID = 1; S_AXI_BREADY = 0;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL premid_bvalid got %b exp 1", S_AXI_BVALID); end
        ARESET = 1;
        @(negedge ACLK);
        checks++;
        if ({S_AXI_BVALID, pwm_out, period_tick, S_AXI_AWREADY} !== 4'b0000) begin
            errors++; $display("FAIL midreset got %b exp 0000", {S_AXI_BVALID, pwm_out, period_tick, S_AXI_AWREADY});
        end
        ARESET = 0;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rresp);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL midreset_reg%0d got %h exp 0", i, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_wstrb();
        test_w_before_aw();
        test_pwm_wave();
        test_duty_update();
        test_boundaries();
        test_same_reg_rw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
